itch_feed_arbiter: RTL

- Shares the single ITCH header parser (`itch_parser`) between NUM_FEEDS independent byte streams; each message is type(1) + length(2, big-endian) + payload(length bytes).
- Grants one feed at a time, round-robin at message boundaries, and holds the grant for the whole message.
- Steers the 3 header bytes to the parser port, inserts the idle cycle the parser needs after each header, and routes the payload bytes to a separate payload port with a last-byte marker.

---
 rtl/itch_feed_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/itch_feed_arbiter.sv
// Round-robin arbiter sharing one ITCH header parser between several byte feeds.
// Header bytes go to the parser port with a guard cycle; payload bytes go to a separate port.
module itch_feed_arbiter #(
    parameter int unsigned NUM_FEEDS = 2,
    parameter int unsigned GID_W     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_FEEDS-1:0] in_data,
    input  logic [NUM_FEEDS-1:0]   in_valid,
    output logic [NUM_FEEDS-1:0]   in_ready,
    output logic [7:0]             hdr_data,
    output logic                   hdr_valid,
    output logic [7:0]             pl_data,
    output logic                   pl_valid,
    output logic                   pl_last,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy
);

    typedef enum logic [2:0] {
        StArb,
        StHdr0,
        StHdr1,
        StHdr2,
        StGap,
        StPayload
    } state_e;

    state_e           state_q, state_d;
    logic [GID_W-1:0] grant_q, grant_d;
    logic [GID_W-1:0] last_grant_q, last_grant_d;
    logic             busy_q, busy_d;
    logic [7:0]       hdr_data_q, hdr_data_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             pl_valid_q, pl_valid_d;
    logic             pl_last_q, pl_last_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      pl_cnt_q, pl_cnt_d;

    logic [GID_W-1:0] pick;
    logic             pick_found;
    logic [7:0]       sel_data;
    logic             sel_valid;

    // First requester scanning upward from the feed after the last winner, with wrap.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_FEEDS; k++) begin
            for (int unsigned i = 0; i < NUM_FEEDS; i++) begin
                if (!pick_found && in_valid[i] &&
                    ((32'(last_grant_q) + k) % NUM_FEEDS) == i) begin
                    pick       = GID_W'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_FEEDS; i++) begin
            if (grant_q == GID_W'(i)) begin
                sel_data  = in_data[8*i +: 8];
                sel_valid = in_valid[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        busy_d       = busy_q;
        hdr_data_d   = hdr_data_q;
        hdr_valid_d  = 1'b0;
        pl_data_d    = pl_data_q;
        pl_valid_d   = 1'b0;
        pl_last_d    = 1'b0;
        len_hi_d     = len_hi_q;
        len_lo_d     = len_lo_q;
        pl_cnt_d     = pl_cnt_q;
        in_ready     = '0;

        unique case (state_q)
            StArb: begin
                if (pick_found) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    busy_d       = 1'b1;
                    state_d      = StHdr0;
                end
            end
            StHdr0: begin
                in_ready[grant_q] = 1'b1;
                if (sel_valid) begin
                    hdr_data_d  = sel_data;
                    hdr_valid_d = 1'b1;
                    state_d     = StHdr1;
                end
            end
            StHdr1: begin
                in_ready[grant_q] = 1'b1;
                if (sel_valid) begin
                    hdr_data_d  = sel_data;
                    hdr_valid_d = 1'b1;
                    len_hi_d    = sel_data;
                    state_d     = StHdr2;
                end
            end
            StHdr2: begin
                in_ready[grant_q] = 1'b1;
                if (sel_valid) begin
                    hdr_data_d  = sel_data;
                    hdr_valid_d = 1'b1;
                    len_lo_d    = sel_data;
                    state_d     = StGap;
                end
            end
            // Parser needs one idle cycle after the third header byte.
            StGap: begin
                if ({len_hi_q, len_lo_q} == 16'd0) begin
                    busy_d  = 1'b0;
                    state_d = StArb;
                end else begin
                    pl_cnt_d = {len_hi_q, len_lo_q};
                    state_d  = StPayload;
                end
            end
            StPayload: begin
                in_ready[grant_q] = 1'b1;
                if (sel_valid) begin
                    pl_data_d  = sel_data;
                    pl_valid_d = 1'b1;
                    if (pl_cnt_q != 16'd0) begin
                        pl_cnt_d = pl_cnt_q - 16'd1;
                    end
                    if (pl_cnt_q == 16'd1) begin
                        pl_last_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = StArb;
                    end
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StArb;
            grant_q      <= '0;
            last_grant_q <= GID_W'(NUM_FEEDS - 1);
            busy_q       <= 1'b0;
            hdr_data_q   <= '0;
            hdr_valid_q  <= 1'b0;
            pl_data_q    <= '0;
            pl_valid_q   <= 1'b0;
            pl_last_q    <= 1'b0;
            len_hi_q     <= '0;
            len_lo_q     <= '0;
            pl_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            hdr_data_q   <= hdr_data_d;
            hdr_valid_q  <= hdr_valid_d;
            pl_data_q    <= pl_data_d;
            pl_valid_q   <= pl_valid_d;
            pl_last_q    <= pl_last_d;
            len_hi_q     <= len_hi_d;
            len_lo_q     <= len_lo_d;
            pl_cnt_q     <= pl_cnt_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign hdr_data  = hdr_data_q;
    assign hdr_valid = hdr_valid_q;
    assign pl_data   = pl_data_q;
    assign pl_valid  = pl_valid_q;
    assign pl_last   = pl_last_q;

endmodule
